// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch port of the pc sequencer.
// Master issues req/addr, slave returns ack/rdata.
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/exec program-counter sequencer (IDLE -> FETCH -> EXEC).
// Define PC_MISALIGN_TRAP_EN to trap misaligned jr targets to TRAP_VEC.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt,
  pc_sequencer_if.master imem,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic        ctrl_jump,
  input  logic        ctrl_jr,
  input  logic        ctrl_branch,
  input  logic        branch_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] addr26,
  input  logic [31:0] rs_val,
  output logic [31:0] pc,
  output logic        busy,
  output logic        trap
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic [31:0] jmp_tgt;
  logic [31:0] jr_tgt;
  logic        jr_bad;
  logic [31:0] next_pc;
  logic        retire;

  assign retire = (state == S_EXEC) && exec_done;

  assign pc_plus4 = pc + 32'd4;
  assign br_off   = {{14{imm16[15]}}, imm16, 2'b00};
  assign jmp_tgt  = {pc_plus4[31:28], addr26, 2'b00};

`ifdef PC_MISALIGN_TRAP_EN
  assign jr_bad = |rs_val[1:0];
  assign jr_tgt = jr_bad ? TRAP_VEC : rs_val;
`else
  logic unused_cfg;
  assign unused_cfg = ^TRAP_VEC;
  assign jr_bad = 1'b0;
  assign jr_tgt = rs_val & 32'hFFFF_FFFC;
`endif

  always_comb begin
    next_pc = pc_plus4;
    if (ctrl_jr)
      next_pc = jr_tgt;
    else if (ctrl_jump)
      next_pc = jmp_tgt;
    else if (ctrl_branch && branch_taken)
      next_pc = pc_plus4 + br_off;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start)
            state <= S_FETCH;
        end
        S_FETCH: begin
          if (imem.imem_ack) begin
            instr       <= imem.imem_rdata;
            instr_valid <= 1'b1;
            state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (exec_done) begin
            pc    <= next_pc;
            state <= halt ? S_IDLE : S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic trap_q;

  always_ff @(posedge clk) begin
    if (rst)
      trap_q <= 1'b0;
    else
      trap_q <= retire && ctrl_jr && jr_bad;
  end

  assign trap = trap_q;
`else
  logic unused_ret;
  assign unused_ret = retire ^ jr_bad;
  assign trap = 1'b0;
`endif

  assign imem.imem_req  = (state == S_FETCH);
  assign imem.imem_addr = pc;
  assign busy           = (state != S_IDLE);

endmodule
